mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Byte-wide memory controller that answers the byte read requests issued by the instruction-fetch stage and the byte read/write requests issued by the MEM stage. It arbitrates the two requesters onto a single synchronous single-port RAM, then returns each read byte or write acknowledge to its owner with a one-cycle valid strobe. It sits between the pipeline stages and the RAM pins at the top level.

## Interface

- `ADDR_W`, default 17: number of RAM address bits driven.
- `RAM_LAT`, default 1: RAM read latency in cycles, measured from the address appearing on `ram_addr_o` to data on `ram_din_i`. Legal values are 1 to 3.

Ports (one per line: name, direction, width, meaning):

- `clk` input 1: the single clock. All state changes on its rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `if_req_i` input 1: IF requests a byte read this cycle.
- `if_addr_i` input 32: IF byte address.
- `if_lock_i` input 1: IF is in the middle of a multi-byte fetch and must keep priority.
- `if_grant_o` output 1: combinational; IF request accepted this cycle.
- `if_valid_o` output 1: registered; one-cycle strobe meaning `if_data_o` is valid.
- `if_data_o` output 8: returned instruction byte.
- `mem_req_i` input 1: MEM requests an access.
- `mem_we_i` input 1: 1 means write, 0 means read.
- `mem_addr_i` input 32: MEM byte address.
- `mem_wdata_i` input 8: write data.
- `mem_grant_o` output 1: combinational; MEM request accepted this cycle.
- `mem_valid_o` output 1: registered; one-cycle strobe for read data or write acknowledge.
- `mem_data_o` output 8: read byte; 0 for a write acknowledge.
- `ram_addr_o` output ADDR_W: registered RAM address.
- `ram_wr_o` output 1: registered RAM write enable.
- `ram_dout_o` output 8: registered RAM write data.
- `ram_din_i` input 8: RAM read data.

## Operation

**Arbitration (combinational, evaluated every cycle)**
- Rule 1: if `if_lock_i` and `if_req_i` are both 1, IF wins.
- Rule 2: otherwise, if `mem_req_i` is 1, MEM wins.
- Rule 3: otherwise, if `if_req_i` is 1, IF wins.
- Otherwise nothing is granted.
- At most one grant is asserted per cycle.
- A request that is not granted is dropped. The requester holds its request until it sees its grant.

**Issue**
- At the clock edge ending a granted cycle:
  - `ram_addr_o` takes the winner's `addr[ADDR_W-1:0]`. Upper address bits are ignored.
  - `ram_wr_o` is 1 only for a MEM write.
  - `ram_dout_o` takes `mem_wdata_i` for a MEM write, and 0 otherwise.
- With no grant, `ram_wr_o` goes to 0, and `ram_addr_o` and `ram_dout_o` go to 0.

**Tracking**
- A shift register of depth RAM_LAT+1 carries a tag for each issued access: `{valid, owner, we}`.
- A tag is pushed for every grant. A bubble (valid = 0) is pushed when there is no grant.
- When a tag reaches the RAM_LAT stage, `ram_din_i` is sampled. On that same edge:
  - IF read: `if_valid_o` is 1 and `if_data_o` takes `ram_din_i`.
  - MEM read: `mem_valid_o` is 1 and `mem_data_o` takes `ram_din_i`.
  - MEM write: `mem_valid_o` is 1 and `mem_data_o` is 0.
- Valid strobes last exactly one cycle. Data outputs hold their last value between strobes.

**Ordering and throughput**
- Accesses are fully pipelined: one grant per cycle, back-to-back.
- Responses return in issue order, each to its own owner.
- A write followed by a read of the same address returns the newly written byte. This holds because the RAM is single-port and the write is issued first.

## Timing

**Reset**
- While `rst` is 0, every register and output is 0: all valid strobes, data outputs, `ram_addr_o`, `ram_wr_o`, `ram_dout_o`, and all tags.
- The grant outputs are forced to 0 during reset.
- Tags in flight when reset is asserted are discarded. No valid strobe for them appears after reset releases.

**Latency**
- Counted from request cycle N (the grant is high in N).
- The address appears on the RAM in cycle N+1.
- `ram_din_i` is sampled at the end of cycle N+RAM_LAT.
- `*_valid_o` is high in cycle N+1+RAM_LAT. With the default, that is cycle N+2.

**Boundary behaviour**
- IF and MEM request in the same cycle with `if_lock_i` = 0: MEM is granted and IF must retry.
- If `if_lock_i` stays high indefinitely, MEM is starved. This is accepted: IF releases the lock after 4 bytes.
- A request whose address differs only above bit ADDR_W-1 hits the same RAM location.

## Test plan

- **Reset check.** Hold `rst`=0 with requests active, then release. Required: all outputs 0 during reset, no grants, no strobes. First strobe arrives exactly 2 cycles after the first grant.
- **IF 4-byte fetch.** RAM[0x10..0x13] = 13,00,00,93. IF requests 0x10 through 0x13 on consecutive cycles with lock high. Required: four `if_valid_o` strobes in consecutive cycles, returning 0x13, 0x00, 0x00, 0x93.
- **Simultaneous requests, no lock.** IF reads 0x20 and MEM reads 0x40 in the same cycle. Required: `mem_grant_o`=1 and `if_grant_o`=0. MEM gets RAM[0x40]. IF is granted the following cycle, and its data arrives one cycle after MEM's.
- **Lock priority.** Same stimulus with `if_lock_i`=1. Required: IF is granted first and MEM is granted next cycle.
- **Write then read.** MEM writes 0xA5 to 0x1234, then reads 0x1234 on the next cycle. Required: `ram_wr_o` pulses for 1 cycle with `ram_addr_o`=0x1234. The write ack shows `mem_data_o`=0, followed by a read strobe with 0xA5.
- **Reset mid-flight.** Assert `rst` the cycle after an IF grant, then release. Required: no `if_valid_o` for that request, and all tags 0.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide memory controller
//
// Arbitrates byte reads from the instruction-fetch stage (IF) and byte
// reads/writes from the MEM stage onto one synchronous single-port RAM,
// then returns each read byte or write acknowledge to its owner as a
// one-cycle valid strobe, in issue order.
//
// Parameters
//   ADDR_W  : RAM address bits driven (must be below 32)
//   RAM_LAT : RAM read latency, address on ram_addr_o -> data on ram_din_i (1..3)
//
// Ports
//   clk, rst                : clock, asynchronous active-low reset
//   if_req_i/addr_i/lock_i  : IF byte read request, lock keeps IF priority
//   if_grant_o              : combinational IF accept
//   if_valid_o/if_data_o    : registered IF response strobe and byte
//   mem_req_i/we_i/addr_i/wdata_i : MEM access request
//   mem_grant_o             : combinational MEM accept
//   mem_valid_o/mem_data_o  : registered MEM response strobe and byte (0 on write ack)
//   ram_addr_o/wr_o/dout_o  : registered RAM address, write enable, write data
//   ram_din_i               : RAM read data

module mem_ctrl #(
    parameter int unsigned ADDR_W  = 17,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    input  logic              if_lock_i,
    output logic              if_grant_o,
    output logic              if_valid_o,
    output logic [7:0]        if_data_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [7:0]        mem_wdata_i,
    output logic              mem_grant_o,
    output logic              mem_valid_o,
    output logic [7:0]        mem_data_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
);

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   we;
    } tag_t;

    logic if_win;
    logic mem_win;
    tag_t tag_in;
    tag_t tag_out;

    // Stage 0 of the tag pipeline is the grant itself (tag_in); stages
    // 1..RAM_LAT are registered, so stage RAM_LAT lines up with ram_din_i.
    tag_t tag_q [1:RAM_LAT];

    // Address bits above ADDR_W alias onto the same RAM location.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr_i[31:ADDR_W], mem_addr_i[31:ADDR_W]};

    // Lock beats MEM, MEM beats unlocked IF; nothing granted in reset.
    always_comb begin
        if_win  = 1'b0;
        mem_win = 1'b0;
        if (rst) begin
            if (if_lock_i && if_req_i) begin
                if_win = 1'b1;
            end else if (mem_req_i) begin
                mem_win = 1'b1;
            end else if (if_req_i) begin
                if_win = 1'b1;
            end
        end
    end

    assign if_grant_o  = if_win;
    assign mem_grant_o = mem_win;

    always_comb begin
        tag_in = '0;
        if (if_win) begin
            tag_in.valid = 1'b1;
            tag_in.owner = OWN_IF;
            tag_in.we    = 1'b0;
        end else if (mem_win) begin
            tag_in.valid = 1'b1;
            tag_in.owner = OWN_MEM;
            tag_in.we    = mem_we_i;
        end
    end

    assign tag_out = tag_q[RAM_LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_addr_o  <= '0;
            ram_wr_o    <= 1'b0;
            ram_dout_o  <= '0;
            if_valid_o  <= 1'b0;
            if_data_o   <= '0;
            mem_valid_o <= 1'b0;
            mem_data_o  <= '0;
            for (int unsigned i = 1; i <= RAM_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            // Issue
            ram_wr_o <= mem_win && mem_we_i;
            if (if_win) begin
                ram_addr_o <= if_addr_i[ADDR_W-1:0];
                ram_dout_o <= '0;
            end else if (mem_win) begin
                ram_addr_o <= mem_addr_i[ADDR_W-1:0];
                ram_dout_o <= mem_we_i ? mem_wdata_i : '0;
            end else begin
                ram_addr_o <= '0;
                ram_dout_o <= '0;
            end

            // Tracking
            tag_q[1] <= tag_in;
            for (int unsigned i = 2; i <= RAM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end

            // Return
            if_valid_o  <= 1'b0;
            mem_valid_o <= 1'b0;
            if (tag_out.valid) begin
                if (tag_out.owner == OWN_IF) begin
                    if_valid_o <= 1'b1;
                    if_data_o  <= ram_din_i;
                end else begin
                    mem_valid_o <= 1'b1;
                    mem_data_o  <= tag_out.we ? '0 : ram_din_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scoreboard bench for mem_ctrl (default parameters).
// Stimulus pushes expected response bytes and their due cycle into per-owner
// queues; an independent monitor pops and compares on every valid strobe.

module tb_mem_ctrl;

    localparam int unsigned ADDR_W = 17;

    logic              clk;
    logic              rst;
    logic              if_req_i;
    logic [31:0]       if_addr_i;
    logic              if_lock_i;
    logic              if_grant_o;
    logic              if_valid_o;
    logic [7:0]        if_data_o;
    logic              mem_req_i;
    logic              mem_we_i;
    logic [31:0]       mem_addr_i;
    logic [7:0]        mem_wdata_i;
    logic              mem_grant_o;
    logic              mem_valid_o;
    logic [7:0]        mem_data_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic              ram_wr_o;
    logic [7:0]        ram_dout_o;
    logic [7:0]        ram_din_i;

    mem_ctrl #(.ADDR_W(ADDR_W), .RAM_LAT(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_lock_i   (if_lock_i),
        .if_grant_o  (if_grant_o),
        .if_valid_o  (if_valid_o),
        .if_data_o   (if_data_o),
        .mem_req_i   (mem_req_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_grant_o (mem_grant_o),
        .mem_valid_o (mem_valid_o),
        .mem_data_o  (mem_data_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wr_o    (ram_wr_o),
        .ram_dout_o  (ram_dout_o),
        .ram_din_i   (ram_din_i)
    );

    // RAM model: latency 1 means data for the address on ram_addr_o is
    // presented in the same cycle; writes commit at the clock edge.
    logic [7:0] ram [0:(1<<ADDR_W)-1];
    assign ram_din_i = ram[ram_addr_o];
    always @(posedge clk) begin
        if (ram_wr_o) ram[ram_addr_o] <= ram_dout_o;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  d;
        int unsigned due;
    } exp_t;

    exp_t if_q[$];
    exp_t mem_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest expectation for its owner.
    always @(negedge clk) begin
        exp_t e;
        if (if_valid_o) begin
            if (if_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL if_strobe: unexpected strobe data 0x%0h (cycle %0d)", if_data_o, cyc);
            end else begin
                e = if_q.pop_front();
                chk("if_data", {24'd0, if_data_o}, {24'd0, e.d});
                chk("if_cycle", cyc, e.due);
            end
        end
        if (mem_valid_o) begin
            if (mem_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL mem_strobe: unexpected strobe data 0x%0h (cycle %0d)", mem_data_o, cyc);
            end else begin
                e = mem_q.pop_front();
                chk("mem_data", {24'd0, mem_data_o}, {24'd0, e.d});
                chk("mem_cycle", cyc, e.due);
            end
        end
    end

    // Drive one cycle of requests at a negedge, check grants, record
    // expectations, and advance to the next negedge.
    task automatic step(input logic ir, input logic [31:0] ia, input logic il,
                        input logic mr, input logic mw, input logic [31:0] ma,
                        input logic [7:0] md, input logic eig, input logic emg,
                        input logic [7:0] edat, input logic push);
        exp_t e;
        if_req_i    = ir;
        if_addr_i   = ia;
        if_lock_i   = il;
        mem_req_i   = mr;
        mem_we_i    = mw;
        mem_addr_i  = ma;
        mem_wdata_i = md;
        #1;
        chk("if_grant", {31'd0, if_grant_o}, {31'd0, eig});
        chk("mem_grant", {31'd0, mem_grant_o}, {31'd0, emg});
        e.d   = edat;
        e.due = cyc + 2;
        if (push && eig) if_q.push_back(e);
        if (push && emg) mem_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 8'h0, 1'b0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_if_grant"},  {31'd0, if_grant_o},  32'd0);
        chk({tag, "_mem_grant"}, {31'd0, mem_grant_o}, 32'd0);
        chk({tag, "_if_valid"},  {31'd0, if_valid_o},  32'd0);
        chk({tag, "_mem_valid"}, {31'd0, mem_valid_o}, 32'd0);
        chk({tag, "_if_data"},   {24'd0, if_data_o},   32'd0);
        chk({tag, "_mem_data"},  {24'd0, mem_data_o},  32'd0);
        chk({tag, "_ram_addr"},  {15'd0, ram_addr_o},  32'd0);
        chk({tag, "_ram_wr"},    {31'd0, ram_wr_o},    32'd0);
        chk({tag, "_ram_dout"},  {24'd0, ram_dout_o},  32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'h00;
        ram[17'h10] = 8'h13;
        ram[17'h11] = 8'h00;
        ram[17'h12] = 8'h00;
        ram[17'h13] = 8'h93;
        ram[17'h20] = 8'h7E;
        ram[17'h40] = 8'h5C;

        // Reset with both requesters active
        rst         = 1'b0;
        if_req_i    = 1'b1;
        if_addr_i   = 32'h10;
        if_lock_i   = 1'b0;
        mem_req_i   = 1'b1;
        mem_we_i    = 1'b1;
        mem_addr_i  = 32'h40;
        mem_wdata_i = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk_outputs_zero("rst");
        end
        @(negedge clk);
        rst = 1'b1;

        // IF 4-byte locked fetch
        step(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 8'h13, 1'b1);
        step(1'b1, 32'h11, 1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 32'h12, 1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 32'h13, 1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 8'h93, 1'b1);
        idle();

        // Simultaneous, no lock: MEM first, IF retries next cycle
        step(1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h40, 8'h0, 1'b0, 1'b1, 8'h5C, 1'b1);
        step(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0,  8'h0, 1'b1, 1'b0, 8'h7E, 1'b1);
        idle();

        // Simultaneous with lock: IF first, MEM next cycle
        step(1'b1, 32'h20, 1'b1, 1'b1, 1'b0, 32'h40, 8'h0, 1'b1, 1'b0, 8'h7E, 1'b1);
        step(1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h40, 8'h0, 1'b0, 1'b1, 8'h5C, 1'b1);
        idle();

        // Write then read of the same location through an aliased address
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h1234, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b1);
        chk("wr_ram_wr",   {31'd0, ram_wr_o},   32'd1);
        chk("wr_ram_addr", {15'd0, ram_addr_o}, 32'h1234);
        chk("wr_ram_dout", {24'd0, ram_dout_o}, 32'hA5);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0002_1234, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1);
        chk("rd_ram_wr",   {31'd0, ram_wr_o},   32'd0);
        chk("rd_ram_addr", {15'd0, ram_addr_o}, 32'h1234);
        chk("rd_ram_dout", {24'd0, ram_dout_o}, 32'h00);
        idle();
        idle();

        // Reset pulse the cycle after an IF grant: that response must vanish
        step(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 8'h00, 1'b0);
        if_req_i = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        #1;
        rst      = 1'b1;
        if_req_i = 1'b0;
        @(negedge clk);
        repeat (4) idle();

        // Bounded drain of outstanding expectations
        for (int k = 0; k < 10 && (if_q.size() + mem_q.size()) != 0; k++) @(negedge clk);
        chk("drain", if_q.size() + mem_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
